// File: rtl/hs_reg_responder.sv
// rtl/hs_reg_responder.sv - valid/ready request/response responder backed by a small register file
//
// Requests {we, addr, wdata, id} are queued in a DEPTH-entry FIFO. An IDLE/WAIT/RESP
// FSM pops them in order, waits LATENCY cycles, executes them against the register
// file and presents one response per request.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready registered)
//   req_we/addr/wdata/id  request payload
//   rsp_valid/rsp_ready   response handshake (rsp_valid registered)
//   rsp_we/data/id/err    response payload; err = address out of range
//   busy                  any accepted request still awaiting its response handshake
module hs_reg_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 12,
    parameter int ID_W       = 4,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2,
    parameter int READY_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ID_W-1:0]   req_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + ID_W;
    localparam int NREG_IMPL = 1 << ADDR_W;

    localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  PTR_ONE    = (PTR_W+1)'(1);
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
    localparam logic [3:0]      LAT_C      = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    logic [3:0]           lat_cnt;
    logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       count_next;
    logic [ENTRY_W-1:0]   head;
    logic [ENTRY_W-1:0]   cur;
    logic [ENTRY_W-1:0]   exec_entry;
    logic [DATA_W-1:0]    regs [NREG_IMPL];

    logic                 push;
    logic                 pop;
    logic                 rsp_hs;
    logic                 fifo_empty;
    logic                 exec_en;
    logic                 active_next;
    logic                 exec_we;
    logic [ADDR_W-1:0]    exec_addr;
    logic [DATA_W-1:0]    exec_wdata;
    logic [ID_W-1:0]      exec_id;
    logic                 exec_in_range;

    // Pointers carry one extra bit so that full (count == DEPTH) and empty differ.
    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    assign push   = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // The head is taken either from IDLE or on the very edge a response completes,
    // which is what allows back-to-back responses.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_hs));

    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + PTR_ONE;
        end
        if (pop) begin
            count_next = count_next - PTR_ONE;
        end
    end

    assign active_next = pop || (state == WAIT) || ((state == RESP) && !rsp_hs);

    // With zero latency the popped head is executed on the pop edge itself;
    // otherwise the held entry executes as WAIT expires.
    assign exec_en    = ((state == WAIT) && (lat_cnt == 4'd1)) || (pop && (LATENCY == 0));
    assign exec_entry = (state == WAIT) ? cur : head;
    assign {exec_we, exec_addr, exec_wdata, exec_id} = exec_entry;
    assign exec_in_range = ({1'b0, exec_addr} < NUM_REGS_C);

    // Payload storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_we, req_addr, req_wdata, req_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cur       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < NREG_IMPL; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (READY_MODE == 0) begin
                req_ready <= (count_next != DEPTH_C);
            end else begin
                // Ready answers a pending valid for exactly one cycle, then drops.
                req_ready <= !req_ready && req_valid && (count_next != DEPTH_C);
            end

            busy <= (count_next != '0) || active_next;

            // Response payload only changes when a new request executes, so it
            // stays stable while a response is stalled.
            if (exec_en) begin
                rsp_we  <= exec_we;
                rsp_id  <= exec_id;
                rsp_err <= !exec_in_range;
                if (exec_we) begin
                    rsp_data <= exec_wdata;
                    if (exec_in_range) begin
                        regs[exec_addr] <= exec_wdata;
                    end
                end else begin
                    rsp_data <= exec_in_range ? regs[exec_addr] : '0;
                end
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            cur     <= head;
                            lat_cnt <= LAT_C;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        lat_cnt   <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        if (pop) begin
                            if (LATENCY == 0) begin
                                rsp_valid <= 1'b1;
                            end else begin
                                cur       <= head;
                                lat_cnt   <= LAT_C;
                                state     <= WAIT;
                                rsp_valid <= 1'b0;
                            end
                        end else begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hs_reg_responder.md
Name: hs_reg_responder

Overview:
- Synthesizable valid/ready request/response responder: the DUT-side slave for the master agent's request/response handshake.
- Accepts read/write requests into a small FIFO, executes them against an internal register file after a programmable latency, and returns one response per request in order.
- Serves as the reference DUT for master-agent, handshake-precedence and checker regressions.

Parameters:
- DATA_W, 32, data width of write data and response data.
- ADDR_W, 4, register address width.
- NUM_REGS, 12, implemented registers, 1..2**ADDR_W; addresses at or above NUM_REGS are out of range.
- ID_W, 4, transaction tag width.
- DEPTH, 4, request FIFO entries, power of 2, at least 2.
- LATENCY, 2, wait cycles between FIFO pop and response valid, 0..15.
- READY_MODE, 0, 0 = DUT-first (ready asserted ahead of valid); 1 = TB-first (ready asserted only after valid is seen).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready, registered.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data.
- req_id  in  ID_W  transaction tag.
- rsp_valid  out  1  response valid, registered.
- rsp_ready  in  1  response ready.
- rsp_we  out  1  echo of req_we.
- rsp_data  out  DATA_W  read data for reads, written data for writes.
- rsp_id  out  ID_W  echo of req_id.
- rsp_err  out  1  address out of range.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0, FIFO empty, all registers 0, FSM IDLE, latency counter 0.
  - In-flight and queued requests are dropped.
  - req_ready rises no earlier than the first clk edge after rst_n deasserts.
- Request handshake: a transfer occurs on a rising edge where req_valid && req_ready. The request {we, addr, wdata, id} is pushed to the FIFO on that edge.
- READY_MODE 0:
  - req_ready is registered as !(full after this edge's push/pop).
  - A pop and a push on the same edge while full are allowed.
- READY_MODE 1:
  - req_ready rises on the edge after req_valid is sampled high with the FIFO not full.
  - req_ready falls on the edge of the handshake.
  - Minimum 2 cycles per request; req_ready never high while req_valid is low.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head. Go to WAIT with counter=LATENCY, or directly to RESP if LATENCY==0.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
  - RESP: rsp_valid=1. On rsp_valid && rsp_ready, if the FIFO is non-empty, pop immediately and go to WAIT (or stay in RESP when LATENCY==0); otherwise go to IDLE and drop rsp_valid.
- Execution happens on the edge entering RESP:
  - Write: updates reg[addr] when in range; rsp_data = wdata.
  - Read: rsp_data = reg[addr] when in range, else 0.
  - rsp_err = (addr >= NUM_REGS). An out-of-range write changes no register.
  - A read sees all earlier writes, in strict FIFO order.
- Latency: request accepted at edge E0 → popped at E1 → rsp_valid high after edge E1+LATENCY.
- LATENCY==0: sustained throughput is 1 response per cycle with rsp_ready held high.
- Response stability: while rsp_valid && !rsp_ready, rsp_we, rsp_data, rsp_id and rsp_err are held stable. rsp_valid is never withdrawn without a handshake.
- Empty FIFO: no pop, FSM remains IDLE.
- Full FIFO: req_ready low (mode 0) or held low (mode 1). No request is lost or duplicated.
- Pointers: DEPTH is a power of 2; pointers wrap modulo DEPTH; an extra count bit distinguishes full from empty.
- busy: registered, high whenever any accepted request has not completed its response handshake.

Test Plan:
- Reset then write id=1 addr=3 data=0xDEADBEEF, read id=2 addr=3, LATENCY=2, rsp_ready=1 → rsp_valid 3 cycles after the first accept edge with id=1, data 0xDEADBEEF, err=0; then id=2, data 0xDEADBEEF, we=0.
- Read addr=13 with NUM_REGS=12, then read addr=0 → first rsp_err=1, data=0; second rsp_err=0, data=0. A write to addr=13 leaves all registers unchanged.
- DEPTH=4, rsp_ready=0, push 6 requests back-to-back → exactly 4 accepted after IDLE pops 1 (5 held total), then req_ready=0. rsp held stable 20 cycles. Release rsp_ready → all accepted responses drain in id order, busy falls 1 cycle after the last handshake.
- READY_MODE=1, req_valid rises at cycle 10 → req_ready high at cycle 11, handshake at edge 11, req_ready low at cycle 12. Never ready before valid.
- LATENCY=0, 8 reads, rsp_ready=1, READY_MODE=0 → 8 consecutive rsp_valid cycles, 1 response per cycle after the first.
- Assert rst_n low mid-WAIT with 3 requests queued → outputs 0 immediately, no responses after release, a register written before reset reads 0.
